// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: sequences START, address+R/W, data bytes, ACK/NACK and STOP
// from the data_clk phase produced by the upstream clock-stretch block.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// READY    | idle, bus released, waiting for ena
// START    | SDA pulled low while SCL still idle-high
// ADDR     | shifting out 7-bit address + R/W, MSB first
// SLV_ACK1 | slave acknowledges the address byte
// WR       | shifting out a data byte, MSB first
// RD       | shifting in a data byte, MSB first
// SLV_ACK2 | slave acknowledges a written byte; host may chain another
// MSTR_ACK | master ACKs (more to read) or NACKs (last byte)
// STOP     | SDA released while SCL high, then back to READY
module i2c_byte_master #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_clk,
  input  logic              ena,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] data_wr,
  input  logic              sda_in,
  output logic              busy,
  output logic [DATA_W-1:0] data_rd,
  output logic              ack_error,
  output logic              sda_oe,
  output logic              scl_not_ena
);

  typedef enum logic [3:0] {
    READY, START, ADDR, SLV_ACK1, WR, RD, SLV_ACK2, MSTR_ACK, STOP
  } state_t;

  state_t            state_q;
  logic [2:0]        bit_cnt_q;
  logic              data_clk_prev_q;
  logic [ADDR_W:0]   addr_rw_q;
  logic [DATA_W-1:0] data_tx_q;
  logic [DATA_W-1:0] rx_buf_q;
  logic [DATA_W-1:0] data_rd_q;
  logic              busy_q;
  logic              ack_error_q;
  logic              sda_oe_q;
  logic              scl_not_ena_q;

  logic upd_edge;
  logic smp_edge;
  logic same_cmd;

  assign upd_edge = data_clk & ~data_clk_prev_q;
  assign smp_edge = ~data_clk & data_clk_prev_q;
  assign same_cmd = ({addr, rw} == addr_rw_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= READY;
      bit_cnt_q       <= 3'd7;
      data_clk_prev_q <= 1'b0;
      addr_rw_q       <= '0;
      data_tx_q       <= '0;
      rx_buf_q        <= '0;
      data_rd_q       <= '0;
      busy_q          <= 1'b0;
      ack_error_q     <= 1'b0;
      sda_oe_q        <= 1'b0;
      scl_not_ena_q   <= 1'b1;
    end else begin
      data_clk_prev_q <= data_clk;
      if (upd_edge) begin
        case (state_q)
          READY: begin
            if (ena) begin
              addr_rw_q   <= {addr, rw};
              data_tx_q   <= data_wr;
              busy_q      <= 1'b1;
              ack_error_q <= 1'b0;
              sda_oe_q    <= 1'b1;
              state_q     <= START;
            end else begin
              busy_q   <= 1'b0;
              sda_oe_q <= 1'b0;
            end
          end
          START: begin
            sda_oe_q  <= ~addr_rw_q[ADDR_W];
            bit_cnt_q <= 3'd7;
            state_q   <= ADDR;
          end
          ADDR: begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= 3'd7;
              state_q   <= SLV_ACK1;
            end else begin
              sda_oe_q  <= ~addr_rw_q[bit_cnt_q - 3'd1];
              bit_cnt_q <= bit_cnt_q - 3'd1;
            end
          end
          SLV_ACK1: begin
            if (!addr_rw_q[0]) begin
              sda_oe_q <= ~data_tx_q[DATA_W-1];
              state_q  <= WR;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= RD;
            end
          end
          WR: begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= 3'd7;
              busy_q    <= 1'b0;
              state_q   <= SLV_ACK2;
            end else begin
              sda_oe_q  <= ~data_tx_q[bit_cnt_q - 3'd1];
              bit_cnt_q <= bit_cnt_q - 3'd1;
            end
          end
          RD: begin
            if (bit_cnt_q == 3'd0) begin
              data_rd_q <= rx_buf_q;
              busy_q    <= 1'b0;
              bit_cnt_q <= 3'd7;
              // ACK only when the host already asks for another byte from the same slave
              sda_oe_q  <= ena & same_cmd;
              state_q   <= MSTR_ACK;
            end else begin
              bit_cnt_q <= bit_cnt_q - 3'd1;
            end
          end
          SLV_ACK2: begin
            if (ena && same_cmd) begin
              data_tx_q <= data_wr;
              busy_q    <= 1'b1;
              sda_oe_q  <= ~data_wr[DATA_W-1];
              state_q   <= WR;
            end else begin
              sda_oe_q <= 1'b1;
              state_q  <= STOP;
            end
          end
          MSTR_ACK: begin
            if (ena && same_cmd) begin
              busy_q   <= 1'b1;
              sda_oe_q <= 1'b0;
              state_q  <= RD;
            end else begin
              sda_oe_q <= 1'b1;
              state_q  <= STOP;
            end
          end
          STOP: begin
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= READY;
          end
          default: state_q <= READY;
        endcase
      end else if (smp_edge) begin
        case (state_q)
          START:              scl_not_ena_q <= 1'b0;
          SLV_ACK1, SLV_ACK2: if (sda_in) ack_error_q <= 1'b1;
          RD:                 rx_buf_q[bit_cnt_q] <= sda_in;
          STOP:               scl_not_ena_q <= 1'b1;
          default: begin
          end
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign data_rd     = data_rd_q;
  assign ack_error   = ack_error_q;
  assign sda_oe      = sda_oe_q;
  assign scl_not_ena = scl_not_ena_q;

endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
- Byte-level I2C master controller sitting directly downstream of the clock-stretch/phase generator.
- Consumes that generator's data_clk phase signal and returns scl_not_ena to it, gating SCL.
- Drives SDA as an open-drain enable and sequences START, 7-bit address + R/W, data bytes, ACK/NACK and STOP.
- Host side uses an ena/busy command handshake, allowing back-to-back bytes to the same address.

Parameters:
ADDR_W, 7, slave address width (only 7 is supported)
DATA_W, 8, data byte width (only 8 is supported)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
data_clk  input  1  phase signal from the stretch block, synchronous to clk
ena  input  1  host command request
addr  input  7  slave address
rw  input  1  0 = write, 1 = read
data_wr  input  8  byte to write
sda_in  input  1  sampled SDA line level
busy  output  1  1 = command in progress; a 1->0 transition means the byte is done and the next command may be presented
data_rd  output  8  last byte read
ack_error  output  1  slave NACKed an address or write byte
sda_oe  output  1  1 = pull SDA low, 0 = release
scl_not_ena  output  1  1 = SCL held idle-high; fed to the stretch block

Behaviour:
- Reset (rst=0, async): state=READY, busy=0, ack_error=0, data_rd=0, sda_oe=0, scl_not_ena=1, bit_cnt=7, data_clk_prev=0, addr_rw/data_tx/rx_buf=0.
- Reset asserted mid-transfer releases the bus immediately; no STOP is generated.
- data_clk_prev registers data_clk every cycle; data_clk needs no synchronizer.
- Update edge: data_clk=1 and prev=0. Sample edge: data_clk=0 and prev=1.
- All state, sda_oe and busy changes happen only on the update edge. sda_in is read only on the sample edge.
- Between edges, every register holds its value.

FSM actions on the update edge:
- READY:
  - ena=1: addr_rw<={addr,rw}, data_tx<=data_wr, busy<=1, ack_error<=0, sda_oe<=1 (START: SDA falls while SCL high), go to START.
  - ena=0: busy<=0, sda_oe<=0.
- START: sda_oe<=~addr_rw[7], bit_cnt<=7, go to ADDR.
- ADDR:
  - bit_cnt=0: sda_oe<=0, bit_cnt<=7, go to SLV_ACK1.
  - Otherwise: sda_oe<=~addr_rw[bit_cnt-1], bit_cnt--.
- SLV_ACK1:
  - rw=0: sda_oe<=~data_tx[7], go to WR.
  - rw=1: sda_oe<=0, go to RD.
- WR:
  - bit_cnt=0: sda_oe<=0, bit_cnt<=7, busy<=0, go to SLV_ACK2.
  - Otherwise: drive ~data_tx[bit_cnt-1], bit_cnt--.
- RD:
  - bit_cnt=0: data_rd<=rx_buf, busy<=0, bit_cnt<=7, go to MSTR_ACK.
  - At that transition, sda_oe<=1 (ACK) if ena=1 and {addr,rw}==addr_rw; otherwise sda_oe<=0 (NACK).
  - Otherwise: bit_cnt--.
- SLV_ACK2:
  - ena=1 and {addr,rw}==addr_rw: data_tx<=data_wr, busy<=1, sda_oe<=~data_wr[7], go to WR.
  - Otherwise: sda_oe<=1, go to STOP.
- MSTR_ACK:
  - ena=1 and same addr_rw: busy<=1, sda_oe<=0, go to RD.
  - Otherwise: sda_oe<=1, go to STOP.
- STOP: sda_oe<=0 (SDA rises while SCL high), busy<=0, go to READY.

Sample-edge actions:
- START: scl_not_ena<=0.
- SLV_ACK1 / SLV_ACK2: if sda_in=1 then ack_error<=1. ack_error is sticky until the next READY accept.
- RD: rx_buf[bit_cnt]<=sda_in, MSB first.
- STOP: scl_not_ena<=1.

Boundary rules:
- ena changes inside ADDR/WR/RD are ignored; ena is evaluated only in READY, SLV_ACK2 and MSTR_ACK.
- A command with a different address or rw always ends in STOP. There is no repeated START; the new command is accepted from READY.
- A NACK does not abort the transfer: the FSM still follows ena, and the host reads ack_error.
- Update and sample edges cannot coincide (both require a data_clk transition in opposite directions).

Test Plan:
- Write 0x5A to address 0x3C, ena dropped after busy rises, sda_in=0 at acks -> sda_oe sequence encodes 0x78 then 0x5A MSB first, ack_error=0, STOP, READY with busy=0, scl_not_ena back to 1.
- Read from 0x50, sda_in driven with 0xC3 during RD, ena=0 -> data_rd=0xC3 at MSTR_ACK entry, NACK (sda_oe=0), STOP.
- Two-byte write 0x11, 0x22 to the same address, ena held with data_wr updated when busy falls -> WR re-entered without STOP, busy pulses 1->0 twice, one STOP at the end.
- Address NACK (sda_in=1 at SLV_ACK1 sample edge) -> ack_error=1, held through STOP, cleared when the next command is accepted.
- Second command with a different address presented at SLV_ACK2 -> STOP, READY, then a fresh START for the new address.
- rst pulled low mid-RD with bit_cnt=3 -> same cycle sda_oe=0, scl_not_ena=1, busy=0, state READY; after release the next command runs normally.
